// File: rtl/spi_pkg.sv
// Constants and types shared by the SPI front end and controller_fsm.
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } hs_state_t;

    localparam logic [7:0] CMD_IMG_SEND_REQUEST = 8'hFE;
    localparam logic [7:0] CMD_CLEAR            = 8'hFD;

    localparam logic [3:0] ST_IDLE      = 4'h0;
    localparam logic [3:0] ST_RECEIVING = 4'h1;
    localparam logic [3:0] ST_COMPUTING = 4'h2;
    localparam logic [3:0] ST_DONE      = 4'h8;
    localparam logic [3:0] ST_ERROR     = 4'hF;

    // Byte shifted back to the host: status in the upper nibble.
    function automatic logic [7:0] tx_byte(input logic [3:0] status, input logic [3:0] result);
        return {status, result};
    endfunction

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Byte handshake and status lines between spi_byte_receiver and controller_fsm.
interface spi_byte_receiver_if #(parameter int CNT_W = 8);
    logic [7:0]       spi_rx_data;
    logic             spi_byte_valid;
    logic             byte_taken;
    logic             rx_enable;
    logic [3:0]       status_code;
    logic [3:0]       result_out;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output spi_rx_data, spi_byte_valid, drop_count,
        input  byte_taken, rx_enable, status_code, result_out
    );

    modport slave (
        input  spi_rx_data, spi_byte_valid, drop_count,
        output byte_taken, rx_enable, status_code, result_out
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Single-bit multi-flop synchroniser with asynchronous reset to a chosen idle level.
module bit_synchronizer #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_byte_receiver.sv
// Mode-0 SPI slave: oversampled RX into a valid/taken byte handshake, status/result on MISO.
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int TAKE_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    spi_byte_receiver_if.master ctl
);
    localparam int               TMR_W    = $clog2(TAKE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TAKE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
    logic sclk_rise, sclk_fall, cs_fall;

    bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk, .rst_n, .d(spi_sclk), .q(sclk_s));
    bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk, .rst_n, .d(spi_cs_n), .q(cs_s));
    bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk, .rst_n, .d(spi_mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;

    // Only seven bits are stored: the eighth is taken straight from mosi_s so the
    // completed byte is available in the cycle of the final rise.
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise & ~cs_s & (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (cs_s) begin
            bit_cnt <= '0;
        end else if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // MISO bit 7 is driven directly; tx_shift holds the remaining bits. The fall that
    // follows a byte-completing rise is skipped so the freshly loaded MSB is held.
    logic [6:0] tx_shift;
    logic [7:0] tx_word;

    assign tx_word = tx_byte(ctl.status_code, ctl.result_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            spi_miso <= 1'b0;
        end else if (cs_s) begin
            spi_miso <= 1'b0;
        end else if (cs_fall || byte_done) begin
            tx_shift <= tx_word[6:0];
            spi_miso <= tx_word[7];
        end else if (sclk_fall && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
            spi_miso <= tx_shift[6];
        end
    end

    hs_state_t        state, state_n;
    logic [7:0]       rx_data_q, pend_data, load_val;
    logic             pend_q, load, set_pend, clr_pend;
    logic [1:0]       n_drop;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] drop_q;

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = rx_byte;
        set_pend = 1'b0;
        clr_pend = 1'b0;
        n_drop   = 2'd0;
        case (state)
            S_IDLE: begin
                if (pend_q) begin
                    state_n  = S_HOLD;
                    load     = 1'b1;
                    load_val = pend_data;
                    clr_pend = 1'b1;
                end else if (byte_done && ctl.rx_enable) begin
                    state_n = S_HOLD;
                    load    = 1'b1;
                end
            end
            S_HOLD: begin
                if (ctl.byte_taken) begin
                    state_n = S_GAP;
                end else if (timer == TMR_LAST) begin
                    state_n = S_GAP;
                    n_drop  = n_drop + 2'd1;
                end
                if (byte_done && ctl.rx_enable) n_drop = n_drop + 2'd1;
            end
            S_GAP: begin
                state_n = S_IDLE;
                if (byte_done && ctl.rx_enable) set_pend = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rx_data_q <= '0;
            pend_data <= '0;
            pend_q    <= 1'b0;
            timer     <= '0;
            drop_q    <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                rx_data_q <= load_val;
                timer     <= '0;
            end else if (state == S_HOLD) begin
                timer <= timer + 1'b1;
            end
            if (set_pend) begin
                pend_q    <= 1'b1;
                pend_data <= rx_byte;
            end else if (clr_pend) begin
                pend_q <= 1'b0;
            end
            if (n_drop != 2'd0)
                drop_q <= (drop_q > CNT_MAX - CNT_W'(n_drop)) ? CNT_MAX : drop_q + CNT_W'(n_drop);
        end
    end

    assign ctl.spi_rx_data    = rx_data_q;
    assign ctl.spi_byte_valid = (state == S_HOLD);
    assign ctl.drop_count     = drop_q;
endmodule

// File: tb/tb_spi_byte_receiver.sv
// Scoreboard bench: host driver pushes expected bytes, a monitor pops them on each valid pulse.
module tb_spi_byte_receiver;
    import spi_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         len;
        int         drops;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, spi_sclk, spi_cs_n, spi_mosi, miso_a, miso_b;

    always #5 clk = ~clk;

    spi_byte_receiver_if #(.CNT_W(8)) ctl_if ();
    spi_byte_receiver_if #(.CNT_W(8)) ovr_if ();

    spi_byte_receiver #(.SYNC_STAGES(2), .TAKE_TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_a), .ctl(ctl_if)
    );

    // Long timeout so a second byte can overrun the first.
    spi_byte_receiver #(.SYNC_STAGES(2), .TAKE_TIMEOUT(1000), .CNT_W(8)) dut_ovr (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(miso_b), .ctl(ovr_if)
    );

    int   checks = 0;
    int   fails = 0;
    int   take_delay = 2;
    int   exp_drops = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int len, input int drops);
        exp_t e;
        e.data = d; e.len = len; e.drops = drops;
        sb.push_back(e);
    endtask

    // Controller model: takes the byte take_delay cycles into valid; 0 means never.
    int vcnt = 0;
    always @(negedge clk) begin
        if (ctl_if.spi_byte_valid) begin
            vcnt++;
            if (take_delay != 0 && vcnt == take_delay) ctl_if.byte_taken = 1'b1;
        end else begin
            vcnt = 0;
            ctl_if.byte_taken = 1'b0;
        end
    end

    exp_t cur;
    bit   in_hi = 1'b0;
    int   hi_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_hi  = 1'b0;
            hi_len = 0;
        end else if (ctl_if.spi_byte_valid) begin
            if (!in_hi) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte: got %02h expected no byte", ctl_if.spi_rx_data);
                    cur.len = -1;
                end else begin
                    cur = sb.pop_front();
                    chk("rx_data", 32'(ctl_if.spi_rx_data), 32'(cur.data));
                end
            end
            in_hi = 1'b1;
            hi_len++;
        end else if (in_hi) begin
            if (cur.len >= 0) begin
                chk("valid_len", hi_len, cur.len);
                chk("drop_count", 32'(ctl_if.drop_count), cur.drops);
            end
            in_hi  = 1'b0;
            hi_len = 0;
        end
    end

    // Host: drive MOSI while SCLK low, sample MISO at the rising edge (10:1 ratio).
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rd);
        rd = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (5) @(negedge clk);
            spi_sclk = 1'b1;
            rd[i] = miso_a;
            repeat (5) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_on();
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (5) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, output logic [7:0] rd);
        cs_on();
        send_bits(b, 8, rd);
        cs_off();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        rst_n = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        ctl_if.rx_enable   = 1'b1;
        ctl_if.status_code = 4'h0;
        ctl_if.result_out  = 4'h0;
        ovr_if.rx_enable   = 1'b1;
        ovr_if.byte_taken  = 1'b1;
        ovr_if.status_code = 4'h0;
        ovr_if.result_out  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_valid", ctl_if.spi_byte_valid, 0);
        chk("rst_data", ctl_if.spi_rx_data, 0);
        chk("rst_drop", ctl_if.drop_count, 0);
        chk("rst_miso", miso_a, 0);
        chk("rst_miso_ovr", miso_b, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Overrun on the long-timeout instance; the main instance takes both normally.
        ovr_if.byte_taken = 1'b0;
        push(8'h01, 2, 0);
        push(8'h02, 2, 0);
        cs_on();
        send_bits(8'h01, 8, rd);
        send_bits(8'h02, 8, rd);
        cs_off();
        chk("ovr_valid", ovr_if.spi_byte_valid, 1);
        chk("ovr_data", ovr_if.spi_rx_data, 8'h01);
        chk("ovr_drop", ovr_if.drop_count, 1);
        ovr_if.byte_taken = 1'b1;

        push(CMD_IMG_SEND_REQUEST, 2, 0);
        frame(CMD_IMG_SEND_REQUEST, rd);

        push(8'hA5, 2, 0);
        push(8'h3C, 2, 0);
        cs_on();
        send_bits(8'hA5, 8, rd);
        send_bits(8'h3C, 8, rd);
        cs_off();

        take_delay = 0;
        exp_drops  = 1;
        push(8'h12, 16, exp_drops);
        frame(8'h12, rd);
        repeat (10) @(negedge clk);
        take_delay = 2;
        push(8'h34, 2, exp_drops);
        frame(8'h34, rd);

        ctl_if.rx_enable = 1'b0;
        frame(8'h55, rd);
        chk("rx_disabled_drop", ctl_if.drop_count, exp_drops);
        ctl_if.rx_enable = 1'b1;

        ctl_if.status_code = ST_DONE;
        ctl_if.result_out  = 4'd7;
        push(8'hC3, 2, exp_drops);
        frame(8'hC3, rd);
        chk("miso_byte", rd, 8'h87);

        cs_on();
        send_bits(8'hB0, 5, rd);
        cs_off();
        push(CMD_CLEAR, 2, exp_drops);
        frame(CMD_CLEAR, rd);

        cs_on();
        send_bits(8'hA0, 4, rd);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ctl_if.spi_byte_valid, 0);
        chk("mid_rst_data", ctl_if.spi_rx_data, 0);
        chk("mid_rst_drop", ctl_if.drop_count, 0);
        chk("mid_rst_miso", miso_a, 0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_drops = 0;
        repeat (5) @(negedge clk);
        push(8'h0F, 2, exp_drops);
        frame(8'h0F, rd);

        for (int i = 0; i < 500 && (sb.size() != 0 || in_hi); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/spi_byte_receiver.md
Name: spi_byte_receiver

Overview:
- SPI slave front end, directly upstream of controller_fsm.
- Mode 0 (CPOL=0, CPHA=0), MSB first. SCLK, CS_N and MOSI are oversampled in the clk domain.
- Presents each received byte to controller_fsm on a valid/taken handshake.
- Shifts {status_code, result} back to the host on MISO, so the host can poll FPGA state.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each SPI input synchroniser; legal range 2..3.
- TAKE_TIMEOUT, 16: clk cycles spi_byte_valid may stay high without byte_taken before the byte is dropped.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock; must be at least 8x SCLK.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  host SPI clock, asynchronous.
- spi_cs_n  in  1  host chip select, active-low, asynchronous.
- spi_mosi  in  1  host data in.
- spi_miso  out  1  data to host.
- rx_enable  in  1  from controller; when low, received bytes are discarded.
- byte_taken  in  1  from controller; acknowledges the presented byte.
- spi_rx_data  out  8  received byte; stable while spi_byte_valid is high.
- spi_byte_valid  out  1  byte presented.
- status_code  in  4  controller status; upper nibble of TX byte.
- result_out  in  4  BNN result; lower nibble of TX byte.
- drop_count  out  CNT_W  saturating count of dropped bytes (overrun or timeout).

Behaviour:
- Reset values, all taken while rst_n is low, from any state including mid-byte:
  - spi_miso=0, spi_rx_data=0, spi_byte_valid=0, drop_count=0
  - bit counter=0, RX/TX shift registers=0, state=S_IDLE
- Synchronisation and edge detect:
  - SCLK, CS_N and MOSI each pass through SYNC_STAGES flops.
  - sclk_rise and sclk_fall are one-cycle pulses from the synchronised SCLK versus its previous value.
  - cs_fall and cs_rise are derived the same way from synchronised CS_N.
- RX shifting:
  - On sclk_rise with synced CS_N low: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt increments (3 bits).
  - On the rise that completes bit 7, a complete byte is formed and bit_cnt wraps to 0.
- Chip-select handling:
  - Synced CS_N high forces bit_cnt=0; a partial byte is silently discarded and not counted.
  - cs_rise does not affect a byte already presented.
- Handshake FSM (handshake states: S_IDLE, S_HOLD, S_GAP):
  - S_IDLE → S_HOLD, when a complete byte arrives and rx_enable=1:
    - register spi_rx_data, assert spi_byte_valid on the next clk edge (1 cycle after the completing sclk_rise);
    - clear the timeout counter.
  - S_IDLE, complete byte with rx_enable=0: byte discarded; not counted as a drop; stay in S_IDLE.
  - S_HOLD → S_GAP, when byte_taken=1: deassert spi_byte_valid.
  - S_HOLD → S_GAP, when the timeout counter reaches TAKE_TIMEOUT-1: deassert spi_byte_valid; drop_count +1.
  - S_HOLD, another complete byte arrives: new byte dropped, drop_count +1; presented byte unchanged.
  - S_HOLD, byte_taken and timeout expiry in the same cycle: byte_taken wins, no drop counted.
  - S_GAP → S_IDLE after exactly 1 cycle. This guarantees spi_byte_valid is low for at least 1 cycle, because controller_fsm detects bytes on the rising edge of valid.
  - S_GAP, complete byte arrives: the byte is held and presented on entry to S_IDLE (1-cycle extra latency); it is not dropped.
- Drop counter: drop_count saturates at all-ones and never wraps.
- TX / MISO:
  - On cs_fall, and on every byte completion while CS_N is low: tx_shift <= {status_code, result_out}; spi_miso <= bit 7 of that value.
  - On sclk_fall with CS_N low: shift left; spi_miso <= next bit.
  - While CS_N is high: spi_miso=0.
  - status_code and result_out are sampled only at the load points.
- Latency:
  - MISO updates within SYNC_STAGES+1 clk of the physical SCLK fall.
  - The 8x ratio guarantees MISO is stable before the next host rise.
- spi_rx_data holds its last value outside S_HOLD.

Decomposition:
- Shared package spi_pkg holds:
  - handshake FSM enum (S_IDLE, S_HOLD, S_GAP);
  - command constants CMD_IMG_SEND_REQUEST=8'hFE and CMD_CLEAR=8'hFD;
  - status code constants, shared with controller_fsm.
- Sub-module bit_synchronizer: SYNC_STAGES-deep single-bit sync with async reset; instantiated three times.

Test Plan:
- Basic RX: clk:SCLK=10:1, CS_N low, send 0xFE, byte_taken 2 cycles after valid → spi_rx_data=0xFE, valid high 2 cycles then low ≥1 cycle, drop_count=0.
- Back-to-back: send 0xA5, 0x3C in one CS frame, controller takes each → two valid rising edges with data 0xA5 then 0x3C, no drops.
- Timeout: send 0x12, never assert byte_taken → valid falls after 16 cycles, drop_count=1. Next byte 0x34 is presented normally.
- Overrun and rx_enable:
  - Hold byte_taken low with TAKE_TIMEOUT=1000, send 0x01 then 0x02 → data stays 0x01, drop_count=1.
  - rx_enable=0, send 0x55 → no valid, drop_count unchanged.
- MISO and partial byte:
  - status_code=4'b1000, result_out=4'd7 → host reads 0x87 on MISO.
  - Raise CS_N after 5 bits, then send full 0xFD → only 0xFD is presented.
- Reset mid-byte: assert rst_n low after 4 bits → all outputs 0; after release, a full 0x0F is received correctly.
